stepper_pulse_driver: RTL

STEPPER_PULSE_DRIVER -- requirements
Module: stepper_pulse_driver

---
 rtl/stepper_pulse_driver.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/stepper_pulse_driver.sv
// Queued stepper-motor phase sequencer: counts step requests, walks a half/full-step
// coil table at STEP_DIV cycles per step, and de-energizes after IDLE_CYCLES of hold.
module stepper_pulse_driver #(
  parameter int unsigned STEP_DIV    = 50000,
  parameter int unsigned IDLE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_req,
  input  logic       dir,
  input  logic       half_step,
  input  logic       flush,
  output logic [3:0] coil,
  output logic       busy,
  output logic [3:0] pending,
  output logic       overflow
);

  localparam int unsigned STW = $clog2(STEP_DIV);
  localparam int unsigned ITW = $clog2(IDLE_CYCLES);
  localparam logic [STW-1:0] STEP_LAST = STW'(STEP_DIV - 1);
  localparam logic [STW-1:0] STEP_ONE  = STW'(1);
  localparam logic [ITW-1:0] IDLE_LAST = ITW'(IDLE_CYCLES - 1);
  localparam logic [ITW-1:0] IDLE_ONE  = ITW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_STEP = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  function automatic logic [3:0] phase_to_coil(input logic [2:0] phase);
    logic [3:0] pat;
    case (phase)
      3'd0:    pat = 4'b1000;
      3'd1:    pat = 4'b1100;
      3'd2:    pat = 4'b0100;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0010;
      3'd5:    pat = 4'b0011;
      3'd6:    pat = 4'b0001;
      3'd7:    pat = 4'b1001;
      default: pat = 4'b0000;
    endcase
    return pat;
  endfunction

  logic [1:0]     state_q, state_d;
  logic [2:0]     phase_q, phase_d;
  logic [STW-1:0] step_tmr_q, step_tmr_d;
  logic [ITW-1:0] idle_tmr_q, idle_tmr_d;
  logic [3:0]     pending_q, pending_d;
  logic           overflow_q, overflow_d;
  logic [3:0]     coil_q, coil_d;
  logic           busy_q, busy_d;
  logic           consume_s;
  logic [2:0]     step_amt_s;

  // Next-state logic: queue accounting, phase advance and FSM sequencing.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    step_tmr_d = step_tmr_q;
    idle_tmr_d = idle_tmr_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;

    // flush pre-empts consumption, so the phase never moves on a flush cycle
    consume_s  = (state_q == S_STEP) && (step_tmr_q == STEP_LAST) && !flush;
    step_amt_s = half_step ? 3'd1 : 3'd2;

    if (flush) begin
      pending_d  = 4'd0;
      overflow_d = 1'b0;
    end else if (step_req && consume_s) begin
      pending_d = pending_q;
    end else if (step_req) begin
      if (pending_q != 4'd15) begin
        pending_d = pending_q + 4'd1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (consume_s) begin
      pending_d = pending_q - 4'd1;
    end else begin
      pending_d = pending_q;
    end

    if (consume_s) begin
      phase_d = dir ? (phase_q + step_amt_s) : (phase_q - step_amt_s);
    end else begin
      phase_d = phase_q;
    end

    case (state_q)
      S_IDLE: begin
        if ((pending_q != 4'd0) && !flush) begin
          state_d    = S_STEP;
          step_tmr_d = {STW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        if (flush || (consume_s && (pending_d == 4'd0))) begin
          state_d    = S_HOLD;
          step_tmr_d = {STW{1'b0}};
          idle_tmr_d = {ITW{1'b0}};
        end else if (consume_s) begin
          step_tmr_d = {STW{1'b0}};
        end else begin
          step_tmr_d = step_tmr_q + STEP_ONE;
        end
      end
      S_HOLD: begin
        if ((pending_q != 4'd0) && !flush) begin
          state_d    = S_STEP;
          step_tmr_d = {STW{1'b0}};
        end else if (idle_tmr_q == IDLE_LAST) begin
          state_d    = S_IDLE;
          idle_tmr_d = {ITW{1'b0}};
        end else begin
          idle_tmr_d = idle_tmr_q + IDLE_ONE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        step_tmr_d = {STW{1'b0}};
        idle_tmr_d = {ITW{1'b0}};
      end
    endcase

    coil_d = (state_d == S_IDLE) ? 4'b0000 : phase_to_coil(phase_d);
    busy_d = (state_d == S_STEP);
  end

  // State and registered outputs; reset de-energizes the coils immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      phase_q    <= 3'd0;
      step_tmr_q <= {STW{1'b0}};
      idle_tmr_q <= {ITW{1'b0}};
      pending_q  <= 4'd0;
      overflow_q <= 1'b0;
      coil_q     <= 4'b0000;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      step_tmr_q <= step_tmr_d;
      idle_tmr_q <= idle_tmr_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      coil_q     <= coil_d;
      busy_q     <= busy_d;
    end
  end

  assign coil     = coil_q;
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule
